// File: rtl/rf_access_ctrl.sv
// Valid/ready command front end for a single-port register file with a registered read response.
// Define RF_ACC_BURST_EN to honour req_len (multi-beat reads); otherwise every read is one beat.
module rf_access_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned LW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [LW-1:0] req_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_last,
    output logic          busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_din,
    input  logic [DW-1:0] rf_dout
);

    typedef enum logic {StIdle, StRd} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_last_q, rsp_last_d;
    logic          slot_free;
    logic          load;
    logic          last_beat;

`ifdef RF_ACC_BURST_EN
    logic [LW-1:0] remain_q, remain_d;

    assign last_beat = (remain_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    always_comb begin
        remain_d = remain_q;
        if (state_q == StIdle && req_valid && !req_write) begin
            remain_d = req_len;
        end else if (load) begin
            remain_d = remain_q - LW'(1);
        end
    end
`else
    logic unused_req_len;

    assign unused_req_len = ^req_len;
    assign last_beat      = 1'b1;
`endif

    assign slot_free = !rsp_valid_q || rsp_ready;
    assign load      = (state_q == StRd) && slot_free;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_last_d  = rsp_last_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && !req_write) begin
                    cur_addr_d = req_addr;
                    state_d    = StRd;
                end
            end
            StRd: begin
                if (slot_free) begin
                    rsp_rdata_d = rf_dout;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = last_beat;
                    cur_addr_d  = cur_addr_q + AW'(1);
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A consumed beat with nothing new behind it empties the slot.
        if (!load && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    // Gated by rst_n so the file never sees a write strobe while reset is held.
    assign rf_we     = rst_n && (state_q == StIdle) && req_valid && req_write;
    assign rf_addr   = (state_q == StIdle) ? req_addr : cur_addr_q;
    assign rf_din    = req_wdata;
    assign busy      = (state_q == StRd) || rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural single-port register file attached.
module tb_rf_access_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned LW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [LW-1:0] req_len = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic          busy;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_dout;

    logic [DW-1:0] mem [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rf_we) mem[rf_addr] <= rf_din;
    end
    assign rf_dout = mem[rf_addr];

    rf_access_ctrl #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .AW   (AW),
        .LW   (LW)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_len  (req_len),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_last (rsp_last),
        .busy     (busy),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_din   (rf_din),
        .rf_dout  (rf_dout)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_len   = len;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] beats [4];
        beats[0] = 8'h1E;
        beats[1] = 8'h1F;
        beats[2] = 8'h10;
        beats[3] = 8'h11;

        // Reset values
        #12;
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_rf_we", rf_we, 0);
        check_val("rst_rsp_rdata", rsp_rdata, 0);
        check_val("rst_rsp_last", rsp_last, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Write 0xA5 to addr 3, then read it on the very next cycle
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd3;
        req_wdata = 8'hA5;
        #0;
        check_val("wr_rf_we", rf_we, 1);
        check_val("wr_rf_addr", rf_addr, 3);
        check_val("wr_rf_din", rf_din, 8'hA5);
        tick();
        start_read(4'd3, 4'd0);
        check_val("raw_req_ready_rd", req_ready, 0);
        check_val("raw_busy_rd", busy, 1);
        check_val("raw_rsp_valid_early", rsp_valid, 0);
        check_val("raw_rf_addr", rf_addr, 3);
        tick();
        check_val("raw_rsp_valid", rsp_valid, 1);
        check_val("raw_rsp_rdata", rsp_rdata, 8'hA5);
        check_val("raw_rsp_last", rsp_last, 1);
        check_val("raw_req_ready_back", req_ready, 1);
        tick();
        check_val("raw_rsp_valid_clr", rsp_valid, 0);
        check_val("raw_busy_clr", busy, 0);

        // Preload addr k with 0x10+k, back-to-back writes
        req_write = 1'b1;
        for (int k = 0; k < 16; k++) begin
            req_valid = 1'b1;
            req_addr  = AW'(k);
            req_wdata = 8'(8'h10 + k);
            tick();
        end
        req_valid = 1'b0;
        req_write = 1'b0;

        // Wrapping burst, no stall
        start_read(4'd14, 4'd3);
        check_val("wrap_rf_addr0", rf_addr, 14);
`ifdef RF_ACC_BURST_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("wrap_valid", rsp_valid, 1);
            check_val("wrap_rdata", rsp_rdata, beats[i]);
            check_val("wrap_last", rsp_last, (i == 3) ? 1 : 0);
            check_val("wrap_req_ready", req_ready, (i == 3) ? 1 : 0);
        end
`else
        tick();
        check_val("single_valid", rsp_valid, 1);
        check_val("single_rdata", rsp_rdata, 8'h1E);
        check_val("single_last", rsp_last, 1);
        check_val("single_req_ready", req_ready, 1);
`endif
        tick();
        check_val("wrap_valid_clr", rsp_valid, 0);

        // Back-pressure after the second beat (first beat when bursts are off)
        start_read(4'd14, 4'd3);
`ifdef RF_ACC_BURST_EN
        tick();
        check_val("bp_beat0", rsp_rdata, 8'h1E);
        tick();
        check_val("bp_beat1", rsp_rdata, 8'h1F);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("bp_hold_valid", rsp_valid, 1);
            check_val("bp_hold_rdata", rsp_rdata, 8'h1F);
            check_val("bp_hold_rf_addr", rf_addr, 0);
            check_val("bp_hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check_val("bp_beat2", rsp_rdata, 8'h10);
        check_val("bp_beat2_last", rsp_last, 0);
        tick();
        check_val("bp_beat3", rsp_rdata, 8'h11);
        check_val("bp_beat3_last", rsp_last, 1);
        check_val("bp_req_ready", req_ready, 1);
`else
        rsp_ready = 1'b0;
        tick();
        check_val("bp_beat0", rsp_rdata, 8'h1E);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("bp_hold_valid", rsp_valid, 1);
            check_val("bp_hold_rdata", rsp_rdata, 8'h1E);
            check_val("bp_hold_busy", busy, 1);
            check_val("bp_hold_req_ready", req_ready, 1);
        end
        rsp_ready = 1'b1;
`endif
        tick();
        check_val("bp_valid_clr", rsp_valid, 0);

        // Asynchronous reset mid-burst
        start_read(4'd14, 4'd3);
        tick();
        tick();
`ifdef RF_ACC_BURST_EN
        check_val("mid_pre_rdata", rsp_rdata, 8'h1F);
        check_val("mid_pre_busy", busy, 1);
`endif
        #3 rst_n = 1'b0;
        #1;
        check_val("mid_rsp_valid", rsp_valid, 0);
        check_val("mid_busy", busy, 0);
        check_val("mid_rf_we", rf_we, 0);
        check_val("mid_req_ready", req_ready, 1);
        check_val("mid_rsp_rdata", rsp_rdata, 0);
        check_val("mid_rsp_last", rsp_last, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("post_idle_rsp_valid", rsp_valid, 0);
        start_read(4'd5, 4'd0);
        tick();
        check_val("post_rsp_valid", rsp_valid, 1);
        check_val("post_rsp_rdata", rsp_rdata, 8'h15);
        check_val("post_rsp_last", rsp_last, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Request/response front end that drives the single-port register file (combinational read, 1-cycle write) from a valid/ready command stream. It sits directly upstream of the register file. It turns single-beat write commands and (optionally burst) read commands into `we`/`Addr`/`Din` cycles. Read data from the file's `Dout` is returned on a registered, back-pressurable response channel.

## Interface
Parameters:
- `DW`, 8: data width; must match the register file.
- `DEPTH`, 256: register file depth; must be a power of two.
- `AW`, `$clog2(DEPTH)`: address width.
- `LW`, 4: burst length field width.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, **asynchronous and active-low**.
- `req_valid`, in, 1: command valid.
- `req_ready`, out, 1: command ready.
- `req_write`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, AW: start address.
- `req_wdata`, in, DW: write data.
- `req_len`, in, LW: read beats minus 1.
- `rsp_valid`, out, 1: read data valid.
- `rsp_ready`, in, 1: read data accepted.
- `rsp_rdata`, out, DW: read data.
- `rsp_last`, out, 1: final beat of a read command.
- `busy`, out, 1: command in progress or response pending.
- `rf_we`, out, 1: to register file `we`.
- `rf_addr`, out, AW: to register file `Addr`.
- `rf_din`, out, DW: to register file `Din`.
- `rf_dout`, in, DW: from register file `Dout`.

## Operation
- FSM has two states: IDLE and RD. Reset state is IDLE.
- `req_ready` = (state == IDLE). It is combinational and reads 1 out of reset.
- Write, accepted in IDLE (`req_valid & req_write`):
  - `rf_we`=1, `rf_addr`=`req_addr`, `rf_din`=`req_wdata` in the same cycle.
  - The file commits at the next edge.
  - No response beat. State stays IDLE, so back-to-back writes run at one per cycle.
- Read, accepted in IDLE:
  - Load `cur_addr`=`req_addr` and `remain`=`req_len`, then go to RD.
- In RD:
  - `rf_addr`=`cur_addr` and `rf_we`=0.
  - The response slot is free when `!rsp_valid | rsp_ready`. When free, at the edge: `rsp_rdata`<=`rf_dout`, `rsp_valid`<=1, `rsp_last`<=(`remain`==0), `cur_addr`<=`cur_addr`+1 mod DEPTH, `remain`<=`remain`-1.
  - When the last beat loads, go to IDLE.
- `rsp_valid` clears at an edge where `rsp_ready`=1 and no new beat loads.
- Back-pressure: while `rsp_valid & !rsp_ready`, `rsp_rdata`, `rsp_last`, `cur_addr`, and `remain` all hold.
- `rf_addr` in IDLE is `req_addr`. `rf_din` is `req_wdata` at all times.
- `busy` = (state == RD) | `rsp_valid`.
- Address wrap: DEPTH-1 increments to 0. A burst of up to 2^LW beats may wrap more than once.
- Reset asserted mid-burst, asynchronously:
  - State goes to IDLE. `rsp_valid`, `rsp_last`, `rf_we`, `busy` go to 0. `rsp_rdata` goes to 0.
  - Remaining beats are dropped.
  - Register file contents are not touched by this block.

## Timing
- Write: accepted at edge E0 and committed at E0. Data is readable through `rf_dout` from the cycle after E0.
- Read: accepted at E0 (state RD after E0); the first beat loads at E1 and `rsp_valid` is high in the cycle after E1.
  - Subsequent beats come one per cycle while `rsp_ready`=1.
  - An N-beat read with no stall occupies N+1 cycles from acceptance to the last `rsp_valid`.
- Read-after-write: a read accepted in the cycle after a write's acceptance returns the new data.
- The next command is accepted in the cycle after the last beat loads (state is back in IDLE). The final beat may still be pending on `rsp_valid` at that point.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_last`=0, `busy`=0, `rf_we`=0.

## Configuration
- `RF_ACC_BURST_EN` defined: `req_len` is honoured (1 to 2^LW beats).
- `RF_ACC_BURST_EN` undefined:
  - `req_len` is ignored and `remain` is not implemented.
  - Every read returns exactly one beat with `rsp_last`=1.
  - Port list is unchanged.

## Test plan
DW=8, DEPTH=16, LW=4.
- Reset check: assert `rst_n`=0 mid-cycle → `rsp_valid`=0, `busy`=0, `rf_we`=0 immediately; `req_ready`=1.
- Write then read: write 0xA5 to addr 3, then read addr 3 with len 0 on the next cycle → single beat with `rsp_rdata`=0xA5, `rsp_last`=1, `rsp_valid` high 1 cycle after read acceptance.
- Wrap burst (macro on): preload addr k with 0x10+k. Read addr 14, len 3 → beats 0x1E, 0x1F, 0x10, 0x11 on consecutive cycles, `rsp_last` only on 0x11.
- Back-pressure: same burst with `rsp_ready`=0 for 3 cycles after beat 2 → 0x1F held stable, `rf_addr` steady at 0, no beat lost or duplicated; `req_ready`=0 until the last beat loads.
- Reset mid-burst: assert reset during beat 2 of a 4-beat read → outputs go to reset values. After release, a read of addr 5 len 0 returns 0x15 with `rsp_last`=1.
- Macro off: read addr 14 with `req_len`=3 → one beat 0x1E with `rsp_last`=1; `req_ready`=1 the following cycle.
